wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter between an ALU and a buffered load path
//
// Purpose: merges ALU results (no backpressure, highest priority) and load
// results (valid/ready) onto a single registered register-file write port.
// Loads that lose to the ALU wait in a 2-entry in-order FIFO. An ALU write
// cancels older buffered loads to the same register.
//
// Ports:
//   Clock, nReset          clock (rising edge), async active-low reset
//   AluValid/AluRw/AluData ALU result, always accepted
//   LdValid/LdReady        load handshake; LdReady = FIFO not full
//   LdRw/LdData            load destination and data
//   We/Rw/WData            registered register-file write port
//   Pending                per-register flag: a valid buffered load targets it
module wb_arbiter #(
  parameter int n         = 16,
  parameter int reg_count = 8,
  parameter int addr_size = 3
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 AluValid,
  input  logic [addr_size-1:0] AluRw,
  input  logic [n-1:0]         AluData,
  input  logic                 LdValid,
  output logic                 LdReady,
  input  logic [addr_size-1:0] LdRw,
  input  logic [n-1:0]         LdData,
  output logic                 We,
  output logic [addr_size-1:0] Rw,
  output logic [n-1:0]         WData,
  output logic [reg_count-1:0] Pending
);

  // FIFO is kept as a shift structure: entry 0 is always the head, and
  // slots at or beyond the occupancy count are held invalid.
  logic [1:0]           r_count;
  logic                 r_ev   [2];
  logic [addr_size-1:0] r_erw  [2];
  logic [n-1:0]         r_ed   [2];
  logic                 r_we;
  logic [addr_size-1:0] r_rw;
  logic [n-1:0]         r_wdata;

  logic [1:0]           w_count;
  logic                 w_ev   [2];
  logic [addr_size-1:0] w_erw  [2];
  logic [n-1:0]         w_ed   [2];
  logic                 w_we;
  logic [addr_size-1:0] w_rw;
  logic [n-1:0]         w_wdata;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_idx;
  logic [reg_count-1:0] w_pending;

  assign LdReady  = (r_count != 2'd2);
  assign w_accept = LdValid && LdReady;

  always_comb begin
    w_we    = 1'b0;
    w_rw    = r_rw;
    w_wdata = r_wdata;
    w_count = r_count;
    w_push  = w_accept;
    w_idx   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_ev[i]  = r_ev[i];
      w_erw[i] = r_erw[i];
      w_ed[i]  = r_ed[i];
    end

    if (AluValid) begin
      w_we    = 1'b1;
      w_rw    = AluRw;
      w_wdata = AluData;
      // The ALU result is younger than anything buffered: kill stale loads.
      for (int i = 0; i < 2; i++) begin
        if (r_erw[i] == AluRw) w_ev[i] = 1'b0;
      end
    end else if (r_count != 2'd0) begin
      w_we    = r_ev[0];
      w_rw    = r_erw[0];
      w_wdata = r_ed[0];
      w_ev[0]  = r_ev[1];
      w_erw[0] = r_erw[1];
      w_ed[0]  = r_ed[1];
      w_ev[1]  = 1'b0;
      w_count  = r_count - 2'd1;
    end else if (w_accept) begin
      w_we    = 1'b1;
      w_rw    = LdRw;
      w_wdata = LdData;
      w_push  = 1'b0;
    end

    // Push lands after any pop; count here is 0 or 1 since LdReady gates it.
    if (w_push) begin
      w_idx        = w_count[0];
      w_ev[w_idx]  = !(AluValid && (LdRw == AluRw));
      w_erw[w_idx] = LdRw;
      w_ed[w_idx]  = LdData;
      w_count      = w_count + 2'd1;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < 2; i++) begin
      if (r_ev[i]) w_pending[r_erw[i]] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_count <= 2'd0;
      r_we    <= 1'b0;
      r_rw    <= '0;
      r_wdata <= '0;
      for (int i = 0; i < 2; i++) begin
        r_ev[i]  <= 1'b0;
        r_erw[i] <= '0;
        r_ed[i]  <= '0;
      end
    end else begin
      r_count <= w_count;
      r_we    <= w_we;
      r_rw    <= w_rw;
      r_wdata <= w_wdata;
      for (int i = 0; i < 2; i++) begin
        r_ev[i]  <= w_ev[i];
        r_erw[i] <= w_erw[i];
        r_ed[i]  <= w_ed[i];
      end
    end
  end

  assign We      = r_we;
  assign Rw      = r_rw;
  assign WData   = r_wdata;
  assign Pending = w_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a queue-based reference model
module tb_wb_arbiter;

  logic        Clock;
  logic        nReset;
  logic        AluValid;
  logic [2:0]  AluRw;
  logic [15:0] AluData;
  logic        LdValid;
  logic        LdReady;
  logic [2:0]  LdRw;
  logic [15:0] LdData;
  logic        We;
  logic [2:0]  Rw;
  logic [15:0] WData;
  logic [7:0]  Pending;

  wb_arbiter #(.n(16), .reg_count(8), .addr_size(3)) dut (
    .Clock(Clock), .nReset(nReset),
    .AluValid(AluValid), .AluRw(AluRw), .AluData(AluData),
    .LdValid(LdValid), .LdReady(LdReady), .LdRw(LdRw), .LdData(LdData),
    .We(We), .Rw(Rw), .WData(WData), .Pending(Pending)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        v;
    logic [2:0]  rw;
    logic [15:0] d;
  } ent_t;

  ent_t        q[$];
  logic        exp_we;
  logic [2:0]  exp_rw;
  logic [15:0] exp_d;
  int          n_vec;
  int          n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    p = '0;
    foreach (q[i]) if (q[i].v) p[q[i].rw] = 1'b1;
    return p;
  endfunction

  // Reference: what the write port shows after the next edge, and the queue after it.
  task automatic model_step(input logic av, input logic [2:0] arw, input logic [15:0] ad,
                            input logic lv, input logic [2:0] lrw, input logic [15:0] ld);
    logic acc;
    ent_t e;
    acc = lv && (q.size() < 2);
    exp_we = 1'b0;
    if (av) begin
      exp_we = 1'b1; exp_rw = arw; exp_d = ad;
      for (int i = 0; i < q.size(); i++) if (q[i].rw == arw) q[i].v = 1'b0;
      if (acc) begin e.v = (lrw != arw); e.rw = lrw; e.d = ld; q.push_back(e); end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = e.v;
      if (e.v) begin exp_rw = e.rw; exp_d = e.d; end
      if (acc) begin e.v = 1'b1; e.rw = lrw; e.d = ld; q.push_back(e); end
    end else if (acc) begin
      exp_we = 1'b1; exp_rw = lrw; exp_d = ld;
    end
  endtask

  task automatic check_all();
    chk("we", {31'd0, We}, {31'd0, exp_we});
    if (exp_we) begin
      chk("rw", {29'd0, Rw}, {29'd0, exp_rw});
      chk("wdata", {16'd0, WData}, {16'd0, exp_d});
    end
    chk("ldready", {31'd0, LdReady}, {31'd0, (q.size() != 2)});
    chk("pending", {24'd0, Pending}, {24'd0, model_pending()});
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at next falling edge.
  task automatic cyc(input logic av, input logic [2:0] arw, input logic [15:0] ad,
                     input logic lv, input logic [2:0] lrw, input logic [15:0] ld);
    AluValid = av; AluRw = arw; AluData = ad;
    LdValid = lv; LdRw = lrw; LdData = ld;
    model_step(av, arw, ad, lv, lrw, ld);
    @(posedge Clock);
    @(negedge Clock);
    check_all();
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
  endtask

  // Reset dropped between edges: outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2 nReset = 1'b0;
    #1;
    q.delete();
    exp_we = 1'b0;
    chk("rst_we", {31'd0, We}, 32'd0);
    chk("rst_pending", {24'd0, Pending}, 32'd0);
    chk("rst_ldready", {31'd0, LdReady}, 32'd1);
    chk("rst_rw", {29'd0, Rw}, 32'd0);
    chk("rst_wdata", {16'd0, WData}, 32'd0);
    AluValid = 1'b0; LdValid = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    exp_we = 1'b0; exp_rw = '0; exp_d = '0;
    nReset = 1'b0;
    AluValid = 1'b0; AluRw = '0; AluData = '0;
    LdValid = 1'b0; LdRw = '0; LdData = '0;
    repeat (2) @(negedge Clock);
    chk("reset_we", {31'd0, We}, 32'd0);
    chk("reset_rw", {29'd0, Rw}, 32'd0);
    chk("reset_wdata", {16'd0, WData}, 32'd0);
    chk("reset_pending", {24'd0, Pending}, 32'd0);
    chk("reset_ldready", {31'd0, LdReady}, 32'd1);
    nReset = 1'b1;
    @(negedge Clock);

    // Bypass
    cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h1234);
    chk("byp_we", {31'd0, We}, 32'd1);
    chk("byp_rw", {29'd0, Rw}, 32'd3);
    chk("byp_wdata", {16'd0, WData}, 32'h1234);
    chk("byp_pending", {24'd0, Pending}, 32'h0);

    // Conflict buffering
    cyc(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd2, 16'h0BBB);
    chk("cf1_rw", {29'd0, Rw}, 32'd1);
    chk("cf1_wdata", {16'd0, WData}, 32'h00AA);
    chk("cf1_pending", {24'd0, Pending}, 32'h04);
    idle();
    chk("cf2_we", {31'd0, We}, 32'd1);
    chk("cf2_rw", {29'd0, Rw}, 32'd2);
    chk("cf2_wdata", {16'd0, WData}, 32'h0BBB);
    chk("cf2_pending", {24'd0, Pending}, 32'h00);

    // Full / backpressure; the load offered while full must be ignored
    cyc(1'b1, 3'd0, 16'h0010, 1'b1, 3'd4, 16'h0044);
    cyc(1'b1, 3'd1, 16'h0011, 1'b1, 3'd5, 16'h0055);
    chk("full_ldready", {31'd0, LdReady}, 32'd0);
    chk("full_pending", {24'd0, Pending}, 32'h30);
    cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd7, 16'hDEAD);
    chk("full_pop1_rw", {29'd0, Rw}, 32'd4);
    chk("full_pop1_wdata", {16'd0, WData}, 32'h0044);
    chk("full_pop1_ldready", {31'd0, LdReady}, 32'd1);
    idle();
    chk("full_pop2_rw", {29'd0, Rw}, 32'd5);
    chk("full_pop2_wdata", {16'd0, WData}, 32'h0055);
    idle();
    chk("full_empty_we", {31'd0, We}, 32'd0);

    // WAW cancel
    cyc(1'b1, 3'd0, 16'h0009, 1'b1, 3'd6, 16'h1111);
    chk("waw_pending_set", {24'd0, Pending}, 32'h40);
    cyc(1'b1, 3'd6, 16'h2222, 1'b0, 3'd0, 16'd0);
    chk("waw_rw", {29'd0, Rw}, 32'd6);
    chk("waw_wdata", {16'd0, WData}, 32'h2222);
    chk("waw_pending_clr", {24'd0, Pending}, 32'h00);
    idle();
    chk("waw_pop_we", {31'd0, We}, 32'd0);

    // Same-cycle WAW
    cyc(1'b1, 3'd7, 16'h0001, 1'b1, 3'd7, 16'h0002);
    chk("sc_rw", {29'd0, Rw}, 32'd7);
    chk("sc_wdata", {16'd0, WData}, 32'h0001);
    chk("sc_pending", {24'd0, Pending}, 32'h00);
    idle();
    chk("sc_pop_we", {31'd0, We}, 32'd0);
    chk("sc_ldready", {31'd0, LdReady}, 32'd1);

    // Async reset with a full FIFO
    cyc(1'b1, 3'd0, 16'h0001, 1'b1, 3'd2, 16'h0022);
    cyc(1'b1, 3'd0, 16'h0002, 1'b1, 3'd3, 16'h0033);
    chk("pre_rst_ldready", {31'd0, LdReady}, 32'd0);
    async_reset();
    idle();
    chk("post_rst_we", {31'd0, We}, 32'd0);
    idle();
    chk("post_rst_we2", {31'd0, We}, 32'd0);

    // Randomized traffic with a mid-run reset
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) async_reset();
      cyc(($urandom_range(0, 99) < 45), 3'($urandom_range(0, 7)), 16'($urandom),
          ($urandom_range(0, 99) < 70), 3'($urandom_range(0, 7)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
